// File: rtl/int_div_op_pkg.sv
// Shared datapath opcodes and the state encoding reused by multi-cycle operators.
package int_div_op_pkg;

  localparam int OPCODE_NONE = 0;
  localparam int OPCODE_ZEXT = 1;
  localparam int OPCODE_SEXT = 2;
  localparam int OPCODE_UDIV = 3;
  localparam int OPCODE_SDIV = 4;
  localparam int OPCODE_UREM = 5;
  localparam int OPCODE_SREM = 6;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FIXUP,
    ST_DONE
  } mc_state_e;

  function automatic bit op_is_signed(int op);
    return (op == OPCODE_SDIV) || (op == OPCODE_SREM);
  endfunction

  function automatic bit op_is_rem(int op);
    return (op == OPCODE_UREM) || (op == OPCODE_SREM);
  endfunction

endpackage

// File: rtl/int_div_op_if.sv
// Operand/result bundle between the scheduler side and a multi-cycle divide operator.
interface int_div_op_if #(
  parameter int W  = 32,
  parameter int RW = 32
);
  logic          enable;
  logic          start;
  logic [W-1:0]  lhs;
  logic [W-1:0]  rhs;
  logic [RW-1:0] ret;
  logic          busy;
  logic          done;

  modport master (output enable, start, lhs, rhs, input ret, busy, done);
  modport slave  (input enable, start, lhs, rhs, output ret, busy, done);
endinterface

// File: rtl/int_div_op_div_step.sv
// One combinational restoring-division step: shift in a dividend bit, subtract if it fits.
module div_step #(
  parameter int W = 32
) (
  input  logic [W:0]   rem_in,
  input  logic         bit_in,
  input  logic [W-1:0] divisor,
  output logic [W:0]   rem_out,
  output logic         q_bit
);
  logic [W:0] shifted;

  // rem_in[W] stands for the bit shifted out; it forces a subtract if ever set.
  assign shifted = {rem_in[W-1:0], bit_in};
  assign q_bit   = rem_in[W] || (shifted >= {1'b0, divisor});
  assign rem_out = q_bit ? (shifted - {1'b0, divisor}) : shifted;
endmodule

// File: rtl/int_div_op.sv
// Multi-cycle integer divide/remainder with fixed W+2 latency, including divide by zero.
module int_div_op
  import int_div_op_pkg::*;
#(
  parameter int ParamOpCode    = OPCODE_NONE,
  parameter int ParamBitWidth  = 32,
  parameter int ReturnBitWidth = 32
) (
  input logic         clk,
  input logic         rst_n,
  int_div_op_if.slave bus
);
  localparam int W  = ParamBitWidth;
  localparam int RW = ReturnBitWidth;
  localparam int CW = $clog2(W + 1);
  localparam bit IS_SIGNED = op_is_signed(ParamOpCode);
  localparam bit IS_REM    = op_is_rem(ParamOpCode);

  if (!((ParamOpCode == OPCODE_UDIV) || (ParamOpCode == OPCODE_SDIV) ||
        (ParamOpCode == OPCODE_UREM) || (ParamOpCode == OPCODE_SREM))) begin : g_bad_op
    $error("int_div_op: unsupported ParamOpCode %0d", ParamOpCode);
  end
  if ((W < 2) || (W > 64)) begin : g_bad_width
    $error("int_div_op: ParamBitWidth %0d out of range 2..64", W);
  end

  mc_state_e     state_reg, state_next;
  logic [W:0]    rem_reg, rem_step;
  logic [W-1:0]  quo_reg, dvs_reg, lhs_reg;
  logic [CW-1:0] cnt_reg;
  logic          q_neg_reg, r_neg_reg, dz_reg;
  logic [RW-1:0] ret_reg, ret_adapt;
  logic          accept, q_bit, lhs_neg, rhs_neg;
  logic [W-1:0]  lhs_mag, rhs_mag, q_fix, r_fix, res;

  assign accept  = bus.enable && bus.start && ((state_reg == ST_IDLE) || (state_reg == ST_DONE));
  assign lhs_neg = IS_SIGNED && bus.lhs[W-1];
  assign rhs_neg = IS_SIGNED && bus.rhs[W-1];
  assign lhs_mag = lhs_neg ? (~bus.lhs + 1'b1) : bus.lhs;
  assign rhs_mag = rhs_neg ? (~bus.rhs + 1'b1) : bus.rhs;

  div_step #(.W(W)) u_step (
    .rem_in  (rem_reg),
    .bit_in  (quo_reg[W-1]),
    .divisor (dvs_reg),
    .rem_out (rem_step),
    .q_bit   (q_bit)
  );

  // Magnitude MIN/-1 yields 2^(W-1), which already reads back as MIN.
  assign q_fix = q_neg_reg ? (~quo_reg + 1'b1) : quo_reg;
  assign r_fix = r_neg_reg ? (~rem_reg[W-1:0] + 1'b1) : rem_reg[W-1:0];
  assign res   = dz_reg ? (IS_REM ? lhs_reg : {W{1'b1}}) : (IS_REM ? r_fix : q_fix);

  if (RW > W) begin : g_ext
    assign ret_adapt = {{(RW - W){IS_SIGNED & res[W-1]}}, res};
  end else begin : g_trunc
    assign ret_adapt = res[RW-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    if (bus.enable) begin
      case (state_reg)
        ST_IDLE:  if (bus.start) state_next = ST_RUN;
        ST_RUN:   if (cnt_reg == CW'(1)) state_next = ST_FIXUP;
        ST_FIXUP: state_next = ST_DONE;
        ST_DONE:  state_next = bus.start ? ST_RUN : ST_IDLE;
        default:  state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rem_reg   <= '0;
      quo_reg   <= '0;
      dvs_reg   <= '0;
      lhs_reg   <= '0;
      cnt_reg   <= '0;
      q_neg_reg <= 1'b0;
      r_neg_reg <= 1'b0;
      dz_reg    <= 1'b0;
      ret_reg   <= '0;
    end else if (bus.enable) begin
      if (accept) begin
        rem_reg   <= '0;
        quo_reg   <= lhs_mag;
        dvs_reg   <= rhs_mag;
        lhs_reg   <= bus.lhs;
        cnt_reg   <= CW'(W);
        q_neg_reg <= lhs_neg ^ rhs_neg;
        r_neg_reg <= lhs_neg;
        dz_reg    <= (bus.rhs == '0);
      end else if (state_reg == ST_RUN) begin
        rem_reg <= rem_step;
        quo_reg <= {quo_reg[W-2:0], q_bit};
        cnt_reg <= cnt_reg - 1'b1;
      end else if (state_reg == ST_FIXUP) begin
        ret_reg <= ret_adapt;
      end
    end
  end

  assign bus.ret  = ret_reg;
  assign bus.busy = (state_reg == ST_RUN) || (state_reg == ST_FIXUP);
  assign bus.done = (state_reg == ST_DONE);
endmodule

// File: tb/tb_int_div_op.sv
// Scoreboard bench: five W=8 operators (all opcodes plus a 16-bit sign-extended SDIV) share one stimulus stream.
module tb_int_div_op;
  import int_div_op_pkg::*;

  localparam int N = 5;
  localparam int W = 8;
  localparam int OPS [N] = '{OPCODE_UDIV, OPCODE_UREM, OPCODE_SDIV, OPCODE_SREM, OPCODE_SDIV};
  localparam int RWS [N] = '{8, 8, 8, 8, 16};

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic       start = 1'b0;
  logic [7:0] lhs = '0;
  logic [7:0] rhs = '0;

  logic [15:0] ret_w [N];
  logic        busy_w [N];
  logic        done_w [N];

  logic [15:0] exp_q [N][$];
  logic [15:0] held [N];
  int  remain = 0;
  int  edge_no = 0;
  bit  exp_busy = 1'b0;
  bit  exp_done = 1'b0;
  bit  last_en = 1'b0;
  bit  last_rst = 1'b0;
  bit  finish_req = 1'b0;
  int  errors = 0;
  int  checks = 0;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < N; gi++) begin : g_dut
    int_div_op_if #(.W(W), .RW(RWS[gi])) bus ();
    assign bus.enable = enable;
    assign bus.start  = start;
    assign bus.lhs    = lhs;
    assign bus.rhs    = rhs;
    int_div_op #(
      .ParamOpCode    (OPS[gi]),
      .ParamBitWidth  (W),
      .ReturnBitWidth (RWS[gi])
    ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
    );
    assign ret_w[gi]  = 16'(bus.ret);
    assign busy_w[gi] = bus.busy;
    assign done_w[gi] = bus.done;
  end

  // Reference: plain truncating integer arithmetic on the operand values.
  function automatic logic [15:0] ref_op(input int op, input int rw, input logic [7:0] a, input logic [7:0] b);
    bit sg = (op == OPCODE_SDIV) || (op == OPCODE_SREM);
    bit rm = (op == OPCODE_UREM) || (op == OPCODE_SREM);
    longint x, y, v;
    logic [7:0] r8;
    if (sg) begin
      x = longint'($signed(a));
      y = longint'($signed(b));
    end else begin
      x = longint'(a);
      y = longint'(b);
    end
    if (b == 8'd0) v = rm ? x : -64'sd1;
    else           v = rm ? (x % y) : (x / y);
    r8 = v[7:0];
    if (rw > 8 && sg) return {{8{r8[7]}}, r8};
    return {8'h00, r8};
  endfunction

  function automatic logic [7:0] pick();
    case ($urandom_range(0, 5))
      0:       return 8'h00;
      1:       return 8'h80;
      2:       return 8'hFF;
      default: return 8'($urandom);
    endcase
  endfunction

  task automatic chk(input string name, input int i, input logic [15:0] act, input logic [15:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s inst%0d (op %0d): got %h expected %h at edge %0d", name, i, OPS[i], act, want, edge_no);
    end
  endtask

  // Transaction-level model: accepts, latency count, expected results queued per operator.
  initial begin
    forever begin
      @(posedge clk);
      edge_no++;
      last_en  = enable;
      last_rst = !rst_n;
      if (!rst_n) begin
        if (exp_busy) for (int i = 0; i < N; i++) void'(exp_q[i].pop_back());
        remain   = 0;
        exp_busy = 1'b0;
        exp_done = 1'b0;
      end else if (enable) begin
        if (start && !exp_busy) begin
          for (int i = 0; i < N; i++) exp_q[i].push_back(ref_op(OPS[i], RWS[i], lhs, rhs));
          $display("issue edge %0d lhs=%h rhs=%h", edge_no, lhs, rhs);
          remain   = W + 1;
          exp_busy = 1'b1;
          exp_done = 1'b0;
        end else begin
          exp_done = (remain == 1);
          if (remain > 0) remain--;
          exp_busy = (remain > 0);
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (edge_no > 0) begin
        for (int i = 0; i < N; i++) begin
          chk("busy", i, 16'(busy_w[i]), 16'(exp_busy));
          chk("done", i, 16'(done_w[i]), 16'(exp_done));
          if (last_rst) held[i] = '0;
          if (done_w[i] && last_en && !last_rst) begin
            if (exp_q[i].size() == 0) begin
              chk("done_without_op", i, 16'(done_w[i]), 16'd0);
            end else begin
              held[i] = exp_q[i].pop_front();
              chk("result", i, ret_w[i], held[i]);
              $display("done edge %0d inst%0d ret=%h expected=%h", edge_no, i, ret_w[i], held[i]);
            end
          end else begin
            chk("ret_hold", i, ret_w[i], held[i]);
          end
        end
      end
      if (finish_req) begin
        for (int i = 0; i < N; i++) chk("pending", i, 16'(exp_q[i].size()), 16'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1);
  end

  task automatic run_op(input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    start = 1'b1;
    lhs = a;
    rhs = b;
    @(negedge clk);
    start = 1'b0;
    repeat (W + 2) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst_n  = 1'b1;
    enable = 1'b1;
    run_op(8'd200, 8'd7);
    run_op(8'hF9, 8'd2);
    run_op(8'h80, 8'hFF);
    run_op(8'h2A, 8'h00);
    run_op(8'h85, 8'h00);
    run_op(8'hF0, 8'd4);

    // Three stalled cycles in RUN push done out by three.
    @(negedge clk); start = 1'b1; lhs = 8'd99; rhs = 8'd5;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    enable = 1'b0;
    repeat (3) @(negedge clk);
    enable = 1'b1;
    repeat (W + 2) @(negedge clk);

    // Start while busy must be ignored.
    @(negedge clk); start = 1'b1; lhs = 8'hC3; rhs = 8'h0B;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    start = 1'b1; lhs = 8'h11; rhs = 8'h01;
    @(negedge clk); start = 1'b0;
    repeat (W + 2) @(negedge clk);

    // Reset during RUN abandons the operation.
    @(negedge clk); start = 1'b1; lhs = 8'h77; rhs = 8'h03;
    @(negedge clk); start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    repeat (W + 3) @(negedge clk);

    // Start held high: back-to-back operations.
    @(negedge clk); start = 1'b1;
    repeat (25) begin
      lhs = pick();
      rhs = pick();
      @(negedge clk);
    end
    start = 1'b0;
    repeat (W + 3) @(negedge clk);

    repeat (400) begin
      enable = ($urandom_range(0, 4) != 0);
      start  = ($urandom_range(0, 2) == 0);
      lhs    = pick();
      rhs    = pick();
      @(negedge clk);
    end
    enable = 1'b1;
    start  = 1'b0;
    for (int k = 0; k < 40 && exp_busy; k++) @(negedge clk);
    repeat (2) @(negedge clk);
    finish_req = 1'b1;
  end
endmodule
